stream_mux_rr: RTL and testbench

- Parametrised successor to the team's fixed 8:1 single-bit gate mux.
- N-channel, W-bit stream multiplexer with a valid/ready handshake on every input and on the output.
- Channel choice is either an explicit select or round-robin arbitration, picked at run time.
- Registered output, one stage. Used where several producers (for example register-file read paths or memory-return sources) share one downstream consumer in the MIPS datapath.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_pick.sv | 51 +++++
 rtl/stream_mux_rr.sv | 177 +++++++++++++++++
 tb/tb_stream_mux_rr.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the parametrised stream multiplexers:
// mode encodings and a constant-foldable ceiling-log2 helper.
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Ceiling log2 with a floor of 1, so a 2-channel mux still gets a 1-bit select.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotates the request vector so the search starts one
// past ptr, priority-encodes the lowest set bit, then maps it back to a
// channel index. Works for any channel count, not only powers of two.
module rr_pick
   import mux_pkg::*;
#(
   parameter  int NUM_CH = 8,
   localparam int SEL_W  = clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  idx
);

   logic [NUM_CH-1:0] w_rot;
   logic              w_found;
   logic [SEL_W-1:0]  w_idx;

   // Channel examined at rotated position k (ptr itself comes last).
   function automatic int rot_idx(input logic [SEL_W-1:0] p, input int k);
      return (int'(p) + 1 + k) % NUM_CH;
   endfunction

   // Rotate requests, then take the first set bit in rotated order.
   always_comb begin
      w_rot   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_rot[k] = req[SEL_W'(rot_idx(ptr, k))];
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_idx   = SEL_W'(rot_idx(ptr, k));
         end
      end
   end

   // Expand the winning index back to a one-hot grant.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant[i] = w_found && (w_idx == SEL_W'(i));
      end
   end

   assign idx = w_idx;

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel, W-bit valid/ready stream mux with a single registered output
// stage. Channel choice is an explicit select (mode_rr=0) or round-robin
// among valid inputs (mode_rr=1), switchable at run time; both modes share
// one fairness pointer so switching into round-robin continues fairly.
// Optional macro STREAM_MUX_LOCK_EN adds in_last/out_last and holds the
// grant on one channel until it delivers a beat with in_last set.
module stream_mux_rr
   import mux_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NUM_CH = 8,
   localparam int SEL_W  = clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode_rr,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_LOCK_EN
   input  logic [NUM_CH-1:0]       in_last,
   output logic                    out_last,
`endif
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   input  logic                    out_ready
);

   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_data;
   logic [SEL_W-1:0]  r_out_ch;
   logic [SEL_W-1:0]  r_ptr;

   logic              w_load_en;
   logic              w_sel_hit;
   logic [NUM_CH-1:0] w_rr_onehot;
   logic [SEL_W-1:0]  w_rr_idx;
   logic [SEL_W-1:0]  w_grant;
   logic              w_grant_vld;
   logic              w_xfer;
   logic [WIDTH-1:0]  w_data;

`ifdef STREAM_MUX_LOCK_EN
   logic              r_locked;
   logic [SEL_W-1:0]  r_lock_ch;
   logic              r_out_last;
   logic              w_lock_hit;
   logic              w_last;
`endif

   // Output stage acts as a full-throughput pipeline register.
   assign w_load_en = !r_out_valid || out_ready;

   rr_pick #(
      .NUM_CH (NUM_CH)
   ) u_rr_pick (
      .req   (in_valid),
      .ptr   (r_ptr),
      .grant (w_rr_onehot),
      .idx   (w_rr_idx)
   );

   // Explicit-select request check; an out-of-range sel matches no channel.
   always_comb begin
      w_sel_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel == SEL_W'(i)) w_sel_hit = in_valid[i];
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   // Is the locked channel currently presenting data?
   always_comb begin
      w_lock_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_lock_ch == SEL_W'(i)) w_lock_hit = in_valid[i];
      end
   end
`endif

   // Grant resolution: lock overrides mode, mode picks select vs round-robin.
   always_comb begin
      w_grant     = sel;
      w_grant_vld = w_sel_hit;
      if (mode_rr == MODE_RR) begin
         w_grant     = w_rr_idx;
         w_grant_vld = |w_rr_onehot;
      end
`ifdef STREAM_MUX_LOCK_EN
      if (r_locked) begin
         w_grant     = r_lock_ch;
         w_grant_vld = w_lock_hit;
      end
`endif
   end

   assign w_xfer = rst_n && w_load_en && w_grant_vld;

   // Ready goes only to the granted channel; forced low during reset.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready[i] = w_xfer && (w_grant == SEL_W'(i));
      end
   end

   // Data (and last) path from the granted channel.
   always_comb begin
      w_data = '0;
`ifdef STREAM_MUX_LOCK_EN
      w_last = 1'b0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_grant == SEL_W'(i)) begin
            w_data = in_data[i*WIDTH +: WIDTH];
`ifdef STREAM_MUX_LOCK_EN
            w_last = in_last[i];
`endif
         end
      end
   end

   // Output register: load on transfer, empty on idle load slot, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
      end else if (w_load_en) begin
         if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_ch    <= w_grant;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Fairness pointer follows the last served channel; with locking it
   // moves only when a packet completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= SEL_W'(NUM_CH - 1);
      end else if (w_xfer) begin
`ifdef STREAM_MUX_LOCK_EN
         if (w_last) r_ptr <= w_grant;
`else
         r_ptr <= w_grant;
`endif
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   // Packet lock: engage on a non-last beat, release on the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked   <= 1'b0;
         r_lock_ch  <= '0;
         r_out_last <= 1'b0;
      end else if (w_xfer) begin
         r_locked   <= !w_last;
         r_lock_ch  <= w_grant;
         r_out_last <= w_last;
      end
   end

   assign out_last = r_out_last;
`endif

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8-channel instance for the main
// scenarios and a 5-channel instance for out-of-range select handling.
// Packet locking scenario is built when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_rr;

   logic         clk;
   logic         rst_n;

   logic         mode_rr;
   logic [2:0]   sel;
   logic [7:0]   in_valid;
   logic [255:0] in_data;
   logic [7:0]   in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [2:0]   out_ch;
   logic         out_ready;

   logic         mode5;
   logic [2:0]   sel5;
   logic [4:0]   in_valid5;
   logic [159:0] in_data5;
   logic [4:0]   in_ready5;
   logic         out_valid5;
   logic [31:0]  out_data5;
   logic [2:0]   out_ch5;
   logic         out_ready5;

`ifdef STREAM_MUX_LOCK_EN
   logic [7:0]   in_last;
   logic         out_last;
   logic [4:0]   in_last5;
   logic         out_last5;
`endif

   int errors;
   int checks;

   stream_mux_rr #(.WIDTH(32), .NUM_CH(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_rr   (mode_rr),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef STREAM_MUX_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   stream_mux_rr #(.WIDTH(32), .NUM_CH(5)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_rr   (mode5),
      .sel       (sel5),
      .in_valid  (in_valid5),
      .in_data   (in_data5),
`ifdef STREAM_MUX_LOCK_EN
      .in_last   (in_last5),
      .out_last  (out_last5),
`endif
      .in_ready  (in_ready5),
      .out_valid (out_valid5),
      .out_data  (out_data5),
      .out_ch    (out_ch5),
      .out_ready (out_ready5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      in_valid5 = '0;
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 8'hFF;
      #3;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++;
      if (out_ch !== 3'd0) begin errors++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
      checks++;
      if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready got=%h exp=00", in_ready); end
      step();
      rst_n    = 1'b1;
      in_valid = '0;
      #1;
   endtask

   task automatic test_sel();
      mode_rr   = 1'b0;
      sel       = 3'd5;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h20) begin errors++; $display("FAIL sel_in_ready got=%h exp=20", in_ready); end
      step();
      in_valid = '0;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sel_out_valid got=%b exp=1", out_valid); end
      checks++;
      if (out_data !== 32'hA5A5_0005) begin errors++; $display("FAIL sel_out_data got=%h exp=a5a50005", out_data); end
      checks++;
      if (out_ch !== 3'd5) begin errors++; $display("FAIL sel_out_ch got=%0d exp=5", out_ch); end
   endtask

   task automatic test_rr_all();
      logic [7:0] exp_ir;
      do_reset();
      mode_rr   = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_ir = 8'h01 << (k % 8);
         #1;
         checks++;
         if (in_ready !== exp_ir) begin errors++; $display("FAIL rr_in_ready cyc=%0d got=%h exp=%h", k, in_ready, exp_ir); end
         step();
         checks++;
         if (out_ch !== 3'(k % 8) || out_valid !== 1'b1) begin
            errors++; $display("FAIL rr_out_ch cyc=%0d got=%0d/v%b exp=%0d/v1", k, out_ch, out_valid, k % 8);
         end
      end
      in_valid = '0;
   endtask

   task automatic test_backpressure();
      logic       rdy_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_ir  [5] = '{8'h04, 8'h00, 8'h80, 8'h00, 8'h04};
      int         exp_ch  [5] = '{2, 2, 7, 7, 2};
      do_reset();
      mode_rr  = 1'b1;
      in_valid = 8'b1000_0100;
      for (int k = 0; k < 5; k++) begin
         out_ready = rdy_pat[k];
         #1;
         checks++;
         if (in_ready !== exp_ir[k]) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%h exp=%h", k, in_ready, exp_ir[k]); end
         step();
         checks++;
         if (out_ch !== 3'(exp_ch[k]) || out_data !== (32'hA5A5_0000 | 32'(exp_ch[k])) || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_out cyc=%0d got=ch%0d/%h exp=ch%0d", k, out_ch, out_data, exp_ch[k]);
         end
      end
      in_valid  = '0;
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_out_of_range();
      mode5      = 1'b0;
      sel5       = 3'd4;
      in_valid5  = 5'h1F;
      out_ready5 = 1'b1;
      #1;
      checks++;
      if (in_ready5 !== 5'h10) begin errors++; $display("FAIL oor_sel4_ready got=%h exp=10", in_ready5); end
      step();
      checks++;
      if (out_valid5 !== 1'b1 || out_ch5 !== 3'd4 || out_data5 !== 32'h5500_0004) begin
         errors++; $display("FAIL oor_sel4_out got=v%b ch%0d %h exp=v1 ch4 55000004", out_valid5, out_ch5, out_data5);
      end
      sel5 = 3'd5;
      #1;
      checks++;
      if (in_ready5 !== 5'h00) begin errors++; $display("FAIL oor_sel5_ready got=%h exp=00", in_ready5); end
      sel5       = 3'd6;
      out_ready5 = 1'b0;
      #1;
      checks++;
      if (in_ready5 !== 5'h00) begin errors++; $display("FAIL oor_sel6_stall_ready got=%h exp=00", in_ready5); end
      step();
      checks++;
      if (out_valid5 !== 1'b1 || out_data5 !== 32'h5500_0004) begin
         errors++; $display("FAIL oor_hold got=v%b %h exp=v1 55000004", out_valid5, out_data5);
      end
      out_ready5 = 1'b1;
      #1;
      checks++;
      if (in_ready5 !== 5'h00) begin errors++; $display("FAIL oor_sel6_ready got=%h exp=00", in_ready5); end
      step();
      checks++;
      if (out_valid5 !== 1'b0) begin errors++; $display("FAIL oor_drain got=v%b exp=v0", out_valid5); end
      in_valid5 = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      mode_rr   = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      step();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 3'd1) begin
         errors++; $display("FAIL arst_pre got=v%b ch%0d exp=v1 ch1", out_valid, out_ch);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (in_ready !== 8'h00) begin errors++; $display("FAIL arst_in_ready got=%h exp=00", in_ready); end
      checks++;
      if (out_data !== 32'h0 || out_ch !== 3'd0) begin
         errors++; $display("FAIL arst_out_regs got=%h ch%0d exp=0 ch0", out_data, out_ch);
      end
      step();
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h01) begin errors++; $display("FAIL arst_first_grant got=%h exp=01", in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 3'd0) begin
         errors++; $display("FAIL arst_first_out got=v%b ch%0d exp=v1 ch0", out_valid, out_ch);
      end
      in_valid = '0;
      step();
   endtask

`ifdef STREAM_MUX_LOCK_EN
   task automatic test_lock();
      int         exp_ch   [4] = '{3, 3, 3, 1};
      logic       exp_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] exp_ir   [4] = '{8'h08, 8'h08, 8'h08, 8'h02};
      logic [7:0] last_pat [4] = '{8'h02, 8'h02, 8'h0A, 8'h0A};
      logic       mode_pat [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] exp_d;
      do_reset();
      sel       = 3'd3;
      in_valid  = 8'h0A;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mode_rr          = mode_pat[k];
         in_last          = last_pat[k];
         in_data[3*32 +: 32] = 32'hB000_0000 | 32'(k);
         #1;
         checks++;
         if (in_ready !== exp_ir[k]) begin errors++; $display("FAIL lock_in_ready beat=%0d got=%h exp=%h", k, in_ready, exp_ir[k]); end
         step();
         exp_d = (exp_ch[k] == 3) ? (32'hB000_0000 | 32'(k)) : 32'hA5A5_0001;
         checks++;
         if (out_ch !== 3'(exp_ch[k]) || out_last !== exp_last[k] || out_data !== exp_d) begin
            errors++; $display("FAIL lock_out beat=%0d got=ch%0d last%b %h exp=ch%0d last%b %h",
                               k, out_ch, out_last, out_data, exp_ch[k], exp_last[k], exp_d);
         end
      end
      in_valid = '0;
      in_data[3*32 +: 32] = 32'hA5A5_0003;
      step();
   endtask
`endif

   initial begin
      errors     = 0;
      checks     = 0;
      rst_n      = 1'b0;
      mode_rr    = 1'b0;
      sel        = '0;
      in_valid   = '0;
      out_ready  = 1'b1;
      mode5      = 1'b0;
      sel5       = '0;
      in_valid5  = '0;
      out_ready5 = 1'b1;
      for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
      for (int i = 0; i < 5; i++) in_data5[i*32 +: 32] = 32'h5500_0000 | 32'(i);
`ifdef STREAM_MUX_LOCK_EN
      in_last  = 8'hFF;
      in_last5 = 5'h1F;
`endif
      #2;
      test_reset();
      test_sel();
      test_rr_all();
      test_backpressure();
      test_out_of_range();
      test_async_reset();
`ifdef STREAM_MUX_LOCK_EN
      test_lock();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
